// File: rtl/serial_subtractor_pkg.sv
// Shared types and default sizing for the digit-serial subtractor.
package serial_subtractor_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;

  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, difference, borrow_out
  );

  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, difference, borrow_out
  );
endinterface

// File: rtl/serial_subtractor_digit.sv
// Combinational DIGIT-bit borrow-ripple subtractor slice (module digit_subtractor).
module digit_subtractor #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] brw_s;

  assign brw_s[0] = bin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign d[i]       = a_d[i] ^ b_d[i] ^ brw_s[i];
    // Borrow when a<b at this bit, or bits equal and a borrow arrives from below.
    assign brw_s[i+1] = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & brw_s[i]);
  end

  assign bout = brw_s[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: a - b - borrow_in, DIGIT bits per cycle.
// Optional saturation to zero on final borrow: define SERIAL_SUBTRACTOR_SAT_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input logic                 clk,
  input logic                 rst,
  serial_subtractor_if.slave  bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             brw_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;

  logic             accept_s;
  logic             last_s;
  logic [DIGIT-1:0] a_sl_s;
  logic [DIGIT-1:0] b_sl_s;
  logic [DIGIT-1:0] d_s;
  logic             bout_s;
  logic [WIDTH-1:0] res_fin_s;

  assign accept_s = (state_r == IDLE) && bus.in_valid;
  assign last_s   = (cnt_r == CW'(NDIG - 1));

  digit_subtractor #(.DIGIT(DIGIT)) u_digit (
    .a_d  (a_sl_s),
    .b_d  (b_sl_s),
    .bin  (brw_r),
    .d    (d_s),
    .bout (bout_s)
  );

  // Select the current operand slice and merge its result into the accumulated value.
  always_comb begin
    a_sl_s    = a_r[cnt_r*DIGIT +: DIGIT];
    b_sl_s    = b_r[cnt_r*DIGIT +: DIGIT];
    res_fin_s = res_r;
    res_fin_s[cnt_r*DIGIT +: DIGIT] = d_s;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        if (bus.out_ready) state_nxt_s = IDLE;
        else               state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, per-digit accumulation and result publication on the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= {CW{1'b0}};
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      res_r  <= {WIDTH{1'b0}};
      brw_r  <= 1'b0;
      diff_r <= {WIDTH{1'b0}};
      bout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            brw_r <= bus.borrow_in;
            cnt_r <= {CW{1'b0}};
          end
        end
        RUN: begin
          res_r <= res_fin_s;
          brw_r <= bout_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            bout_r <= bout_s;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
            diff_r <= bout_s ? {WIDTH{1'b0}} : res_fin_s;
`else
            diff_r <= res_fin_s;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  // in_ready is gated by rst so it reads 0 while reset is held.
  assign bus.in_ready   = (state_r == IDLE) && !rst;
  assign bus.out_valid  = (state_r == DONE);
  assign bus.difference = diff_r;
  assign bus.borrow_out = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (16/4 and 8/8 instances).
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;

  serial_subtractor_if #(.WIDTH(16)) if16 ();
  serial_subtractor_if #(.WIDTH(8))  if8  ();

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  serial_subtractor #(.WIDTH(8),  .DIGIT(8)) u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef SERIAL_SUBTRACTOR_SAT_EN
  localparam logic [15:0] NEG16 = 16'h0000;
`else
  localparam logic [15:0] NEG16 = 16'hFFFF;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op on the 16-bit unit, scramble inputs, wait for out_valid.
  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, input logic [15:0] exp_d, input logic exp_bo);
    int lat;
    lat = 0;
    if16.a = a; if16.b = b; if16.borrow_in = bin; if16.in_valid = 1'b1;
    check_eq({tag, "_rdy"}, 32'(if16.in_ready), 32'd1);
    tick();
    if16.in_valid = 1'b0; if16.a = ~a; if16.b = a; if16.borrow_in = ~bin;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (if16.out_valid) begin
        lat = k;
        break;
      end
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd4);
    check_eq({tag, "_diff"}, 32'(if16.difference), 32'(exp_d));
    check_eq({tag, "_bo"}, 32'(if16.borrow_out), 32'(exp_bo));
  endtask

  initial begin
    int seen;
    int acc_q[$];
    logic acc;
    tests = 0; fails = 0; cyc = 0;
    rst = 1'b1;
    if16.in_valid = 1'b0; if16.a = 16'h0; if16.b = 16'h0; if16.borrow_in = 1'b0; if16.out_ready = 1'b1;
    if8.in_valid = 1'b0;  if8.a = 8'h0;   if8.b = 8'h0;   if8.borrow_in = 1'b0;  if8.out_ready = 1'b1;
    tick(); tick();
    check_eq("rst_rdy", 32'(if16.in_ready), 32'd0);
    check_eq("rst_ov", 32'(if16.out_valid), 32'd0);
    check_eq("rst_diff", 32'(if16.difference), 32'd0);
    check_eq("rst_bo", 32'(if16.borrow_out), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_rdy", 32'(if16.in_ready), 32'd1);

    run16("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
    tick();
    check_eq("basic_ov_1cyc", 32'(if16.out_valid), 32'd0);
    check_eq("basic_idle", 32'(if16.in_ready), 32'd1);
    check_eq("basic_hold", 32'(if16.difference), 32'h1000);

    run16("under", 16'h0001, 16'h0002, 1'b0, NEG16, 1'b1);
    tick();
    run16("bin_only", 16'h0000, 16'h0000, 1'b1, NEG16, 1'b1);
    tick();
    run16("equal", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
    tick();
    run16("mixed", 16'hA5C3, 16'h5A3C, 1'b1, 16'h4B86, 1'b0);
    tick();

    // Back-pressure in DONE with in_valid pulsing.
    if16.out_ready = 1'b0;
    run16("stall", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if16.in_valid = k[0]; if16.a = 16'h0003; if16.b = 16'h0001;
      #1;
      check_eq("stall_rdy", 32'(if16.in_ready), 32'd0);
      tick();
      check_eq("stall_ov", 32'(if16.out_valid), 32'd1);
      check_eq("stall_diff", 32'(if16.difference), 32'h7FFF);
    end
    if16.in_valid = 1'b0;
    if16.out_ready = 1'b1;
    tick();
    check_eq("stall_release_ov", 32'(if16.out_valid), 32'd0);
    check_eq("stall_release_rdy", 32'(if16.in_ready), 32'd1);
    check_eq("stall_idle_hold", 32'(if16.difference), 32'h7FFF);

    // Reset during the second RUN cycle.
    if16.a = 16'h5555; if16.b = 16'h1111; if16.borrow_in = 1'b0; if16.in_valid = 1'b1;
    tick();
    if16.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_eq("midrst_rdy", 32'(if16.in_ready), 32'd0);
    check_eq("midrst_ov", 32'(if16.out_valid), 32'd0);
    check_eq("midrst_diff", 32'(if16.difference), 32'd0);
    check_eq("midrst_bo", 32'(if16.borrow_out), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("midrst_after_rdy", 32'(if16.in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (if16.out_valid) seen++;
    end
    check_eq("midrst_no_ov", 32'(seen), 32'd0);
    run16("after_rst", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0);
    tick();

    // Single-digit instance: latency 1.
    if8.a = 8'h80; if8.b = 8'h01; if8.borrow_in = 1'b0; if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0; if8.a = 8'h00; if8.b = 8'hFF;
    tick();
    check_eq("w8_ov", 32'(if8.out_valid), 32'd1);
    check_eq("w8_diff", 32'(if8.difference), 32'h7F);
    check_eq("w8_bo", 32'(if8.borrow_out), 32'd0);
    tick();

    // Back-to-back: accepts every NDIG+2 = 3 cycles.
    if8.a = 8'h10; if8.b = 8'h20; if8.in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      acc = if8.in_ready;
      tick();
      if (acc) acc_q.push_back(cyc);
    end
    if8.in_valid = 1'b0;
    check_eq("b2b_count", 32'(acc_q.size()), 32'd4);
    if (acc_q.size() >= 3) begin
      check_eq("b2b_gap1", 32'(acc_q[1] - acc_q[0]), 32'd3);
      check_eq("b2b_gap2", 32'(acc_q[2] - acc_q[1]), 32'd3);
    end
    check_eq("b2b_diff", 32'(if8.difference), 32'hF0);
    check_eq("b2b_bo", 32'(if8.borrow_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, meaning bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, with NDIG = WIDTH/DIGIT.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operands and borrow_in are valid.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 a  input  WIDTH  minuend, unsigned.
REQ-009 b  input  WIDTH  subtrahend, unsigned.
REQ-010 borrow_in  input  1  incoming borrow, subtracted at the LSB.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 difference  output  WIDTH  result of a - b - borrow_in.
REQ-014 borrow_out  output  1  final borrow; 1 when a < b + borrow_in.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE while rst is low.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 Accept SHALL occur on an edge where in_valid & in_ready: latch a, b and borrow_in, clear the digit counter, and go IDLE->RUN.
REQ-019 Each RUN cycle SHALL subtract one DIGIT-bit slice, LSB slice first, with the borrow chained from the previous slice (borrow_in for slice 0).
REQ-020 Each RUN cycle SHALL shift the result slice into the result register and increment the digit counter.
REQ-021 After the NDIG-th RUN cycle the FSM SHALL go RUN->DONE, so out_valid rises on the NDIG-th rising edge after the accepting edge.
REQ-022 On an edge with out_valid & out_ready the FSM SHALL go DONE->IDLE; the earliest next accept is the following edge.
REQ-023 Sustained throughput SHALL be one operation per NDIG+2 cycles.
REQ-024 difference and borrow_out SHALL be stable for the whole time out_valid is high, regardless of out_ready.
REQ-025 difference and borrow_out SHALL hold their last values in IDLE and RUN until the next DONE.
REQ-026 in_valid SHALL be ignored in RUN and DONE; input changes after accept SHALL NOT affect the result.
REQ-027 Arithmetic SHALL be unsigned modulo 2^WIDTH; borrow_out is the borrow out of bit WIDTH-1.
REQ-028 The case NDIG=1 SHALL be legal: one RUN cycle, latency 1.

Reset
REQ-029 rst high SHALL immediately force IDLE, digit counter 0, and in_ready, out_valid, difference and borrow_out all 0.
REQ-030 rst asserted mid-RUN or in DONE SHALL discard the operation with no output.
REQ-031 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-032 With macro SERIAL_SUBTRACTOR_SAT_EN defined, a final borrow_out=1 SHALL force difference to 0 in DONE; borrow_out stays 1.
REQ-033 Without SERIAL_SUBTRACTOR_SAT_EN, difference SHALL be the wrapped modulo-2^WIDTH value.

Structure
REQ-034 Package serial_subtractor_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH/DIGIT constants.
REQ-035 Sub-module digit_subtractor SHALL be a combinational DIGIT-bit borrow-ripple slice (a_d, b_d, bin -> d, bout) built from per-bit XOR difference / (~a & b) borrow logic.
REQ-036 digit_subtractor SHALL be instantiated once and reused every RUN cycle.

Verification
REQ-037 WIDTH=16, DIGIT=4: a=0x1234, b=0x0234, borrow_in=0, out_ready=1 -> difference=0x1000, borrow_out=0, out_valid on the 4th edge after accept, high exactly one cycle.
REQ-038 a=0x0001, b=0x0002 -> difference=0xFFFF and borrow_out=1; with SERIAL_SUBTRACTOR_SAT_EN defined, difference=0x0000 and borrow_out=1.
REQ-039 a=0x0000, b=0x0000, borrow_in=1 -> difference=0xFFFF, borrow_out=1; a=b=0xFFFF, borrow_in=0 -> 0x0000, borrow_out=0.
REQ-040 out_ready held low 5 cycles in DONE, in_valid pulsed during that time -> out_valid and outputs held stable, in_ready=0, no new accept; out_ready=1 -> IDLE next edge.
REQ-041 rst pulsed on the 2nd RUN cycle -> all outputs 0 and in_ready=0 during rst, IDLE afterwards, no out_valid; a new operation afterwards completes correctly.
REQ-042 WIDTH=8, DIGIT=8: a=0x80, b=0x01 -> difference=0x7F, borrow_out=0, out_valid 1 edge after accept; back-to-back operations -> accepts spaced 3 cycles.
